// File: rtl/monitor_pkg.sv
// Shared encodings for the debug monitor view controller.
package monitor_pkg;

  localparam int NUM_VIEWS = 6;

  localparam logic [2:0] VIEW_PC = 3'd0;
  localparam logic [2:0] VIEW_A  = 3'd1;
  localparam logic [2:0] VIEW_X  = 3'd2;
  localparam logic [2:0] VIEW_Y  = 3'd3;
  localparam logic [2:0] VIEW_SP = 3'd4;
  localparam logic [2:0] VIEW_P  = 3'd5;

  // Label word is {LABEL_PREFIX, 1'b0, view}
  localparam logic [11:0] LABEL_PREFIX = 12'hF00;

  typedef enum logic {
    ST_LABEL = 1'b0,
    ST_VALUE = 1'b1
  } state_e;

  // Step the view index forward or backward with wrap over 0..5
  function automatic logic [2:0] view_step(input logic [2:0] v, input logic fwd);
    if (fwd) return (v == VIEW_P)  ? VIEW_PC : v + 3'd1;
    else     return (v == VIEW_PC) ? VIEW_P  : v - 3'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One active-low button: 2-FF synchronizer, stability counter, press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  // Accept the synced level once it has differed for DEBOUNCE_CYCLES samples
  assign flip = (sync2_q != state_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

  // Synchronizer idles at released so reset never fakes a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Counter restarts whenever the sample agrees; pulse only on accepted 1->0
  always_comb begin
    state_d = state_q;
    press_d = flip & state_q;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (flip) begin
      cnt_d   = '0;
      state_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/monitor_view_ctrl.sv
// Display sequencer: button debounce, view select, label splash, freeze, auto-rotate.
module monitor_view_ctrl
  import monitor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ROTATE_CYCLES   = 100000000,
  parameter int LABEL_CYCLES    = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_n,
  input  logic [15:0] PC_reg,
  input  logic [7:0]  A_reg,
  input  logic [7:0]  X_reg,
  input  logic [7:0]  Y_reg,
  input  logic [7:0]  SP_reg,
  input  logic [7:0]  P_reg,
  output logic [15:0] display_value,
  output logic [2:0]  view_sel,
  output logic        label_active,
  output logic        frozen,
  output logic        auto_mode
);
  localparam int RW = $clog2(ROTATE_CYCLES + 1);
  localparam int LW = $clog2(LABEL_CYCLES + 1);

  // press[0] next, [1] prev, [2] freeze toggle, [3] auto toggle
  logic [3:0] press;

  for (genvar b = 0; b < 4; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .btn_n_i (btn_n[b]),
      .press_o (press[b])
    );
  end

  logic [NUM_VIEWS-1:0][15:0] live;
  assign live[VIEW_PC] = PC_reg;
  assign live[VIEW_A]  = {8'h00, A_reg};
  assign live[VIEW_X]  = {8'h00, X_reg};
  assign live[VIEW_Y]  = {8'h00, Y_reg};
  assign live[VIEW_SP] = {8'h00, SP_reg};
  assign live[VIEW_P]  = {8'h00, P_reg};

  state_e                     state_q, state_d;
  logic [2:0]                 view_q, view_d;
  logic                       view_chg;
  logic [LW-1:0]              lab_cnt_q, lab_cnt_d;
  logic [RW-1:0]              rot_cnt_q, rot_cnt_d;
  logic                       lab_done, rot_tick;
  logic                       frozen_q, auto_q;
  logic [NUM_VIEWS-1:0][15:0] snap_q;
  logic [15:0]                disp_q, disp_d;

  assign lab_done = (state_q == ST_LABEL) && (lab_cnt_q == LW'(LABEL_CYCLES - 1));
  assign rot_tick = (state_q == ST_VALUE) && auto_q && (rot_cnt_q == RW'(ROTATE_CYCLES - 1));

  // View arbitration: manual beats auto; next+prev together cancel and eat the tick
  always_comb begin
    view_d   = view_q;
    view_chg = 1'b0;
    if (press[0] && !press[1]) begin
      view_d   = view_step(view_q, 1'b1);
      view_chg = 1'b1;
    end else if (press[1] && !press[0]) begin
      view_d   = view_step(view_q, 1'b0);
      view_chg = 1'b1;
    end else if (!press[0] && !press[1] && rot_tick) begin
      view_d   = view_step(view_q, 1'b1);
      view_chg = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_VALUE;
    else       state_q <= state_d;
  end

  // FSM next state: any view change (re)starts the label
  always_comb begin
    state_d = state_q;
    if (view_chg)      state_d = ST_LABEL;
    else if (lab_done) state_d = ST_VALUE;
  end

  // FSM outputs: label flag and next display word
  always_comb begin
    label_active = (state_q == ST_LABEL);
    if (state_q == ST_LABEL) disp_d = {LABEL_PREFIX, 1'b0, view_q};
    else if (frozen_q)       disp_d = snap_q[view_q];
    else                     disp_d = live[view_q];
  end

  // Label counter runs only in LABEL; rotate counter only in VALUE with auto on
  always_comb begin
    lab_cnt_d = (view_chg || lab_done || state_q != ST_LABEL) ? '0 : lab_cnt_q + 1'b1;
    rot_cnt_d = rot_cnt_q;
    if (view_chg || !auto_q || rot_tick) rot_cnt_d = '0;
    else if (state_q == ST_VALUE)        rot_cnt_d = rot_cnt_q + 1'b1;
  end

  // View, counters and the registered display word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      view_q    <= VIEW_PC;
      lab_cnt_q <= '0;
      rot_cnt_q <= '0;
      disp_q    <= 16'h0000;
    end else begin
      view_q    <= view_d;
      lab_cnt_q <= lab_cnt_d;
      rot_cnt_q <= rot_cnt_d;
      disp_q    <= disp_d;
    end
  end

  // Freeze captures all views on the same edge; auto toggle is independent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frozen_q <= 1'b0;
      auto_q   <= 1'b0;
      snap_q   <= '0;
    end else begin
      if (press[2]) begin
        if (!frozen_q) snap_q <= live;
        frozen_q <= ~frozen_q;
      end
      if (press[3]) auto_q <= ~auto_q;
    end
  end

  assign display_value = disp_q;
  assign view_sel      = view_q;
  assign frozen        = frozen_q;
  assign auto_mode     = auto_q;

endmodule

// File: tb/tb_monitor_view_ctrl.sv
// Bench for monitor_view_ctrl: cycle model + directed literal checks + random run.
module tb_monitor_view_ctrl;
  localparam int D = 4;
  localparam int R = 20;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btn_n = 4'hF;
  logic [15:0] PC_reg = 16'h0;
  logic [7:0]  A_reg = 8'h0, X_reg = 8'h0, Y_reg = 8'h0, SP_reg = 8'h0, P_reg = 8'h0;
  logic [15:0] display_value;
  logic [2:0]  view_sel;
  logic        label_active, frozen, auto_mode;

  monitor_view_ctrl #(.DEBOUNCE_CYCLES(D), .ROTATE_CYCLES(R), .LABEL_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n),
    .PC_reg(PC_reg), .A_reg(A_reg), .X_reg(X_reg), .Y_reg(Y_reg), .SP_reg(SP_reg), .P_reg(P_reg),
    .display_value(display_value), .view_sel(view_sel), .label_active(label_active),
    .frozen(frozen), .auto_mode(auto_mode)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  // Raw button history: bit k = raw level sampled k edges ago
  logic [D+1:0] m_hist [4];
  logic         m_acc [4];
  logic         m_pulse [4];
  int           m_view, m_lab_left, m_rot;
  bit           m_label, m_frozen, m_auto;
  logic [15:0]  m_snap [6];
  logic [15:0]  m_disp;

  function automatic logic [15:0] live_val(input int v);
    case (v)
      0: return PC_reg;
      1: return {8'h00, A_reg};
      2: return {8'h00, X_reg};
      3: return {8'h00, Y_reg};
      4: return {8'h00, SP_reg};
      5: return {8'h00, P_reg};
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_hist[b] = '1; m_acc[b] = 1'b1; m_pulse[b] = 1'b0;
    end
    for (int i = 0; i < 6; i++) m_snap[i] = 16'h0;
    m_view = 0; m_lab_left = 0; m_rot = 0;
    m_label = 0; m_frozen = 0; m_auto = 0; m_disp = 16'h0;
  endtask

  task automatic model_step();
    logic [15:0] nd;
    bit tick, chg;
    int nv;
    nd   = m_label ? (16'hF000 | 16'(m_view)) : (m_frozen ? m_snap[m_view] : live_val(m_view));
    tick = !m_label && m_auto && (m_rot == R - 1);
    chg  = 0; nv = m_view;
    if (m_pulse[0] && !m_pulse[1])               begin nv = (m_view + 1) % 6; chg = 1; end
    else if (m_pulse[1] && !m_pulse[0])          begin nv = (m_view + 5) % 6; chg = 1; end
    else if (!m_pulse[0] && !m_pulse[1] && tick) begin nv = (m_view + 1) % 6; chg = 1; end
    if (chg || !m_auto || tick) m_rot = 0;
    else if (!m_label)          m_rot++;
    if (chg) begin m_label = 1; m_lab_left = L; end
    else if (m_label) begin
      m_lab_left--;
      if (m_lab_left == 0) m_label = 0;
    end
    m_view = nv;
    if (m_pulse[2]) begin
      if (!m_frozen) begin
        for (int i = 0; i < 6; i++) m_snap[i] = live_val(i);
        m_frozen = 1;
      end else m_frozen = 0;
    end
    if (m_pulse[3]) m_auto = !m_auto;
    m_disp = nd;
    // A level is accepted once the last D synced samples (raw delayed 2) all differ from it
    for (int b = 0; b < 4; b++) begin
      m_hist[b]  = {m_hist[b][D:0], btn_n[b]};
      m_pulse[b] = 1'b0;
      if (m_hist[b][D+1:2] == {D{~m_acc[b]}}) begin
        m_pulse[b] = m_acc[b];
        m_acc[b]   = ~m_acc[b];
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else       model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.display_value", display_value, m_disp);
      chk("model.view_sel", 16'(view_sel), 16'(m_view));
      chk("model.label_active", 16'(label_active), 16'(m_label));
      chk("model.frozen", 16'(frozen), 16'(m_frozen));
      chk("model.auto_mode", 16'(auto_mode), 16'(m_auto));
    end
  end

  // Observation counters for the directed checks
  int          lab_cycles = 0;
  int          disp_lab   = 0;
  logic [15:0] last_lab   = 16'h0;
  always @(negedge clk) begin
    if (label_active) lab_cycles++;
    if (display_value[15:12] == 4'hF) begin
      disp_lab++;
      last_lab = display_value;
    end
  end

  task automatic press(input logic [3:0] mask, input int hold, input int idle);
    @(negedge clk); #1;
    btn_n = ~mask;
    repeat (hold) @(negedge clk);
    #1 btn_n = 4'hF;
    repeat (idle) @(negedge clk);
  endtask

  task automatic clr_obs();
    @(negedge clk); #1;
    lab_cycles = 0; disp_lab = 0; last_lab = 16'h0;
  endtask

  task automatic wait_rise(input int budget, output int t, output bit ok);
    logic prev;
    prev = label_active; ok = 0; t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (label_active && !prev) begin ok = 1; t = cyc; break; end
      prev = label_active;
    end
    if (!ok) begin
      vectors++; errors++;
      $display("FAIL label_rise_timeout: got none expected rise within %0d cycles", budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary expected finish before %0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    int          t, t0, vp;
    bit          ok;
    int unsigned r, hold, msk;

    // Reset state
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset.display", display_value, 16'h0000);
    chk("reset.view", 16'(view_sel), 16'h0);
    #1 reset = 1'b0; PC_reg = 16'h1234;

    // Reset mid-label, button released with it
    @(negedge clk); #1 btn_n[0] = 1'b0;
    wait_rise(20, t, ok);
    #1 reset = 1'b1; btn_n = 4'hF;
    @(negedge clk);
    chk("midreset.display", display_value, 16'h0000);
    chk("midreset.view", 16'(view_sel), 16'h0);
    chk("midreset.label", 16'(label_active), 16'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("release.display", display_value, 16'h1234);
    chk("release.view", 16'(view_sel), 16'h0);
    chk("release.flags", 16'({label_active, frozen, auto_mode}), 16'h0);

    // Glitches on next must be ignored, a long hold advances exactly once
    A_reg = 8'hA5;
    clr_obs();
    press(4'b0001, 2, 2);
    press(4'b0001, 2, 2);
    chk("glitch.view", 16'(view_sel), 16'h0);
    chk("glitch.label", 16'(lab_cycles), 16'h0);
    press(4'b0001, 10, 10);
    chk("next.view", 16'(view_sel), 16'h1);
    chk("next.label_cycles", 16'(lab_cycles), 16'd3);
    chk("next.label_words", 16'(disp_lab), 16'd3);
    chk("next.label_word", last_lab, 16'hF001);
    chk("next.value", display_value, 16'h00A5);

    // Prev from view 0 wraps to 5
    press(4'b0010, 6, 12);
    chk("prev.view0", 16'(view_sel), 16'h0);
    P_reg = 8'h3C;
    clr_obs();
    press(4'b0010, 6, 12);
    chk("prev.view", 16'(view_sel), 16'h5);
    chk("prev.label_cycles", 16'(lab_cycles), 16'd3);
    chk("prev.label_word", last_lab, 16'hF005);
    chk("prev.value", display_value, 16'h003C);

    // Freeze snapshot at view 0
    press(4'b0001, 6, 12);
    @(negedge clk); #1 PC_reg = 16'hC000;
    press(4'b0100, 6, 4);
    chk("freeze.on", 16'(frozen), 16'h1);
    @(negedge clk); #1 PC_reg = 16'hC010;
    repeat (3) @(negedge clk);
    chk("freeze.hold", display_value, 16'hC000);
    press(4'b0100, 6, 4);
    chk("freeze.off", 16'(frozen), 16'h0);
    chk("freeze.live", display_value, 16'hC010);

    // Auto-rotate: 20-cycle value + 3-cycle label per view, wrapping 5->0
    press(4'b1000, 6, 0);
    wait_rise(40, t0, ok);
    vp = view_sel;
    for (int k = 0; k < 7; k++) begin
      wait_rise(40, t, ok);
      chk("auto.period", 16'(t - t0), 16'd23);
      chk("auto.view", 16'(view_sel), 16'((vp + 1) % 6));
      t0 = t; vp = view_sel;
    end
    // Manual next mid-count restarts label and rotate count
    repeat (11) @(negedge clk);
    press(4'b0001, 6, 0);
    wait_rise(30, t0, ok);
    chk("auto.manual_view", 16'(view_sel), 16'((vp + 1) % 6));
    wait_rise(40, t, ok);
    chk("auto.restart_period", 16'(t - t0), 16'd23);
    chk("auto.after_view", 16'(view_sel), 16'((vp + 2) % 6));

    // Auto off, then next+prev together: no change, no label
    press(4'b1000, 6, 30);
    chk("auto.off", 16'(auto_mode), 16'h0);
    vp = view_sel;
    clr_obs();
    press(4'b0011, 8, 10);
    chk("both.view", 16'(view_sel), 16'(vp));
    chk("both.label", 16'(lab_cycles), 16'h0);

    // Randomized run against the model
    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 99);
      @(negedge clk); #1;
      if (r < 3) begin
        reset = 1'b1; btn_n = 4'hF;
        @(negedge clk); #1 reset = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          PC_reg = 16'($urandom); A_reg = 8'($urandom); X_reg = 8'($urandom);
          Y_reg = 8'($urandom); SP_reg = 8'($urandom); P_reg = 8'($urandom);
        end
        msk  = (r < 60) ? (32'd1 << $urandom_range(0, 3)) : $urandom_range(0, 15);
        hold = $urandom_range(1, 8);
        btn_n = ~msk[3:0];
        repeat (hold) @(negedge clk);
        #1 btn_n = 4'hF;
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
